backlight_zone_streamer: RTL and testbench

Parametrised successor of the single-frame MiniLED zone writer. It double-buffers per-zone grey levels arriving on the system clock and periodically emits the driver start pulse (`sdbpflag`). It then streams N_ZONES scaled 16-bit brightness words to the LED-driver write port under a valid/ready handshake. It sits between the zone-statistics block and the LED-driver SPI/serialiser. It adds frame-synchronous bank swapping, back-pressure, a chase test pattern and overrun reporting.

---
 rtl/backlight_zone_streamer.sv | 215 +++++++++++++++++++++
 tb/tb_backlight_zone_streamer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/backlight_zone_streamer.sv
// Double-buffered MiniLED zone store: periodic sdbpflag frame pulse followed by a
// valid/ready stream of N_ZONES scaled brightness words to the LED-driver port.
//   state  | meaning
//   S_INIT | waiting out the driver configuration time
//   S_IDLE | frame counter running, waiting for pc == 0
//   S_FLAG | sdbpflag high (pc = 1..FLAG_LEN)
//   S_SEND | streaming zone beats until the last one is accepted
module backlight_zone_streamer #(
    parameter int N_ZONES    = 360,
    parameter int ZONE_AW    = 9,
    parameter int IN_W       = 8,
    parameter int OUT_W      = 16,
    parameter int COLS       = 24,
    parameter int CFG_WAIT   = 2500,
    parameter int PERIOD     = 420000,
    parameter int FLAG_LEN   = 29,
    parameter logic [OUT_W-1:0] FULL_LEVEL = OUT_W'(16'hDF20),
    parameter int CHASE_HOLD = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [ZONE_AW-1:0] in_addr,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_frame_end,
    input  logic [2:0]         mode,
    input  logic [7:0]         bright,
    output logic               sdbpflag,
    output logic               wt_valid,
    input  logic               wt_ready,
    output logic [ZONE_AW-1:0] wt_addr,
    output logic [OUT_W-1:0]   wt_data,
    output logic               cfg_done,
    output logic               overrun
);

    localparam int PC_W = $clog2(PERIOD);
    localparam int CW   = $clog2(CFG_WAIT + 1);
    localparam int HW   = $clog2(CHASE_HOLD + 1);
    localparam int CLW  = $clog2(COLS);
    localparam int PW   = IN_W + 8;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_FLAG, S_SEND} state_t;
    state_t state, state_nx;

    logic [CW-1:0]      cfg_cnt;
    logic [PC_W-1:0]    pc;
    logic               pending, front_valid, back_sel;
    logic [2:0]         cur_mode;
    logic [7:0]         cur_bright;
    logic [ZONE_AW-1:0] chase_pos, cur_chase;
    logic [HW-1:0]      hold_cnt;

    logic [ZONE_AW-1:0] rd_addr, s1_addr;
    logic [CLW-1:0]     col;
    logic               issue_done, s1_valid, s1_left;
    logic [IN_W-1:0]    rd_q;

    logic [IN_W-1:0]    bank0 [N_ZONES];
    logic [IN_W-1:0]    bank1 [N_ZONES];

    logic frame_start, frame_skip, last_accept, addr_ok;
    logic issuing, s1_load, s2_load;

    assign frame_start = (state == S_IDLE) && cfg_done && (pc == '0);
    assign frame_skip  = ((state == S_FLAG) || (state == S_SEND)) && cfg_done && (pc == '0);
    assign last_accept = wt_valid && wt_ready && (wt_addr == ZONE_AW'(N_ZONES - 1));
    assign addr_ok     = ({1'b0, in_addr} < (ZONE_AW + 1)'(N_ZONES));

    assign issuing = (state == S_SEND) && !issue_done;
    assign s2_load = s1_valid && (!wt_valid || wt_ready);
    assign s1_load = issuing && (!s1_valid || s2_load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_INIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        sdbpflag = 1'b0;
        case (state)
            S_INIT: if (cfg_cnt == '0) state_nx = S_IDLE;
            S_IDLE: if (frame_start) state_nx = S_FLAG;
            S_FLAG: begin
                sdbpflag = 1'b1;
                if (pc == PC_W'(FLAG_LEN)) state_nx = S_SEND;
            end
            S_SEND: if (last_accept) state_nx = S_IDLE;
            default: state_nx = S_INIT;
        endcase
    end

    // pc stays at 0 until configuration is done so the first frame starts immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_cnt  <= CW'(CFG_WAIT - 1);
            cfg_done <= 1'b0;
            pc       <= '0;
        end else begin
            if (state == S_INIT) begin
                if (cfg_cnt == '0) cfg_done <= 1'b1;
                else               cfg_cnt  <= cfg_cnt - CW'(1);
            end
            if (cfg_done) pc <= (pc == PC_W'(PERIOD - 1)) ? '0 : pc + PC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= 1'b0;
            front_valid <= 1'b0;
            back_sel    <= 1'b0;
            cur_mode    <= '0;
            cur_bright  <= '0;
            cur_chase   <= '0;
            chase_pos   <= '0;
            hold_cnt    <= HW'(CHASE_HOLD - 1);
            overrun     <= 1'b0;
        end else begin
            overrun <= frame_skip;
            if (frame_start) begin
                cur_mode   <= mode;
                cur_bright <= bright;
                cur_chase  <= chase_pos;
                if (hold_cnt == '0) begin
                    hold_cnt  <= HW'(CHASE_HOLD - 1);
                    chase_pos <= (chase_pos == ZONE_AW'(N_ZONES - 1)) ? '0 : chase_pos + ZONE_AW'(1);
                end else begin
                    hold_cnt <= hold_cnt - HW'(1);
                end
                if (pending || in_frame_end) begin
                    back_sel    <= ~back_sel;
                    front_valid <= 1'b1;
                    pending     <= 1'b0;
                end
            end else if (in_frame_end) begin
                pending <= 1'b1;
            end
        end
    end

    // zone banks are not reset; front bank is the one not selected for writes
    always_ff @(posedge clk) begin
        if (in_valid && addr_ok) begin
            if (back_sel) bank1[in_addr] <= in_data;
            else          bank0[in_addr] <= in_data;
        end
        if (s1_load) rd_q <= back_sel ? bank0[rd_addr] : bank1[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr    <= '0;
            col        <= '0;
            issue_done <= 1'b0;
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            s1_left    <= 1'b0;
        end else begin
            if (frame_start) begin
                rd_addr    <= '0;
                col        <= '0;
                issue_done <= 1'b0;
            end else if (s1_load) begin
                rd_addr <= rd_addr + ZONE_AW'(1);
                col     <= (col == CLW'(COLS - 1)) ? '0 : col + CLW'(1);
                if (rd_addr == ZONE_AW'(N_ZONES - 1)) issue_done <= 1'b1;
            end
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_addr  <= rd_addr;
                s1_left  <= (col < CLW'(COLS / 2));
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    logic [IN_W-1:0]  d;
    logic [PW-1:0]    prod_255, prod_br;
    logic [OUT_W-1:0] beat_word;

    always_comb begin
        d         = front_valid ? rd_q : '0;
        prod_255  = {8'd0, d} * PW'(255);
        prod_br   = {8'd0, d} * {{IN_W{1'b0}}, cur_bright};
        beat_word = '1;
        case (cur_mode)
            3'd0: beat_word = FULL_LEVEL;
            3'd1: beat_word = s1_left ? FULL_LEVEL : OUT_W'(prod_255);
            3'd2: beat_word = OUT_W'(prod_br);
            3'd3: beat_word = OUT_W'(prod_255);
            3'd4: beat_word = (s1_addr == cur_chase) ? '1 : '0;
            default: beat_word = '1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wt_valid <= 1'b0;
            wt_addr  <= '0;
            wt_data  <= '0;
        end else if (s2_load) begin
            wt_valid <= 1'b1;
            wt_addr  <= s1_addr;
            wt_data  <= beat_word;
        end else if (wt_valid && wt_ready) begin
            wt_valid <= 1'b0;
            wt_addr  <= '0;
            wt_data  <= '0;
        end
    end

endmodule

// File: tb/tb_backlight_zone_streamer.sv
// Directed/randomised bench for backlight_zone_streamer against a frame-level
// model of the two zone banks, mode scaling and chase position.
module tb_backlight_zone_streamer;

    localparam int N_ZONES    = 360;
    localparam int ZONE_AW    = 9;
    localparam int IN_W       = 8;
    localparam int OUT_W      = 16;
    localparam int COLS       = 24;
    localparam int CFG_WAIT   = 40;
    localparam int PERIOD     = 1200;
    localparam int FLAG_LEN   = 29;
    localparam int CHASE_HOLD = 3;
    localparam logic [15:0] FULL = 16'hDF20;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic [ZONE_AW-1:0] in_addr = '0;
    logic [IN_W-1:0]    in_data = '0;
    logic               in_frame_end = 1'b0;
    logic [2:0]         mode = '0;
    logic [7:0]         bright = '0;
    logic               wt_ready = 1'b1;
    logic               sdbpflag, wt_valid, cfg_done, overrun;
    logic [ZONE_AW-1:0] wt_addr;
    logic [OUT_W-1:0]   wt_data;

    backlight_zone_streamer #(
        .N_ZONES(N_ZONES), .ZONE_AW(ZONE_AW), .IN_W(IN_W), .OUT_W(OUT_W), .COLS(COLS),
        .CFG_WAIT(CFG_WAIT), .PERIOD(PERIOD), .FLAG_LEN(FLAG_LEN),
        .FULL_LEVEL(FULL), .CHASE_HOLD(CHASE_HOLD)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_frame_end(in_frame_end), .mode(mode), .bright(bright), .sdbpflag(sdbpflag),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_addr(wt_addr), .wt_data(wt_data),
        .cfg_done(cfg_done), .overrun(overrun)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    int ovr_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model state
    int bank_m [2][N_ZONES];
    int back_m = 0;
    bit pend_m = 0;
    bit fv_m = 0;
    int nstarts = 0;
    int mode_l, bright_l, chase_l;
    int rel, last_start;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int z);
        int d;
        d = fv_m ? bank_m[1 - back_m][z] : 0;
        case (mode_l)
            0: return FULL;
            1: return ((z % COLS) < (COLS / 2)) ? FULL : 16'(d * 255);
            2: return 16'(d * bright_l);
            3: return 16'(d * 255);
            4: return (z == chase_l) ? 16'hFFFF : 16'h0000;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic write_all(input int kind);
        int v;
        for (int z = 0; z < N_ZONES; z++) begin
            case (kind)
                0: v = z % 256;
                1: v = 'h40;
                2: v = 'hFF;
                default: v = int'($urandom_range(0, 255));
            endcase
            in_valid = 1'b1;
            in_addr = ZONE_AW'(z);
            in_data = IN_W'(v);
            bank_m[back_m][z] = v;
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            in_addr = ZONE_AW'(N_ZONES + int'($urandom_range(0, 511 - N_ZONES)));
            in_data = IN_W'($urandom);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic commit();
        in_frame_end = 1'b1;
        pend_m = 1;
        tick();
        in_frame_end = 1'b0;
    endtask

    task automatic release_reset();
        rst = 1'b0;
        rel = cyc;
        pend_m = 0;
        fv_m = 0;
        back_m = 0;
        nstarts = 0;
        while (cyc < rel + CFG_WAIT - 1) tick();
        chk("cfg_not_yet", cfg_done, 0);
        tick();
        chk("cfg_done_rise", cfg_done, 1);
    endtask

    task automatic long_stall(input int start);
        int o0;
        logic [ZONE_AW-1:0] ha;
        logic [OUT_W-1:0] hd;
        wt_ready = 1'b0;
        o0 = ovr_cnt;
        ha = wt_addr;
        hd = wt_data;
        tick();
        write_all(3);
        commit();
        while (cyc - start < PERIOD + 60) tick();
        chk("long_stall_hold", {wt_valid, wt_addr, wt_data}, {1'b1, ha, hd});
        chk("overrun_once", ovr_cnt - o0, 1);
        chk("no_flag_on_skip", sdbpflag, 0);
        wt_ready = 1'b1;
    endtask

    task automatic run_frame(input int pct, input int exp_start, input int bright_chg, input bit stall_long);
        int guard, start, e, fl;
        bit stalled, seen, pulled;
        logic [ZONE_AW-1:0] ha;
        logic [OUT_W-1:0] hd;
        guard = 0;
        while (sdbpflag !== 1'b1 && guard < 3 * PERIOD) begin tick(); guard++; end
        chk("flag_arrives", sdbpflag, 1);
        start = cyc - 1;
        if (exp_start >= 0) chk("frame_start_cyc", start, exp_start);
        last_start = start;
        mode_l = int'(mode);
        bright_l = int'(bright);
        chase_l = (nstarts / CHASE_HOLD) % N_ZONES;
        nstarts++;
        if (pend_m) begin back_m = 1 - back_m; fv_m = 1; pend_m = 0; end
        fl = 0;
        while (sdbpflag === 1'b1 && fl < 2 * FLAG_LEN) begin tick(); fl++; end
        chk("flag_len", fl, FLAG_LEN);
        e = 0; guard = 0; stalled = 0; seen = 0; pulled = 0;
        ha = '0; hd = '0;
        while (e < N_ZONES && guard < 4 * PERIOD) begin
            if (stalled) chk("stall_hold", {wt_valid, wt_addr, wt_data}, {1'b1, ha, hd});
            if (wt_valid === 1'b1) begin
                if (!seen) chk("first_valid_pc", cyc - start, FLAG_LEN + 3);
                seen = 1;
                wt_ready = ($urandom_range(0, 99) < pct);
                if (stall_long && e == 5 && !pulled) begin
                    pulled = 1;
                    long_stall(start);
                end
                if (wt_ready) begin
                    chk("beat_addr", wt_addr, e);
                    chk("beat_data", wt_data, exp_word(e));
                    if (e == N_ZONES - 1 && pct == 100 && !stall_long)
                        chk("last_beat_pc", cyc - start, FLAG_LEN + 2 + N_ZONES);
                    e++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    ha = wt_addr;
                    hd = wt_data;
                end
            end else begin
                chk("idle_zero", {wt_addr, wt_data}, 0);
                wt_ready = ($urandom_range(0, 99) < pct);
                stalled = 0;
            end
            if (bright_chg >= 0 && e == 100) bright = 8'(bright_chg);
            tick();
            guard++;
        end
        chk("beats_done", e, N_ZONES);
        chk("valid_after_last", wt_valid, 0);
        wt_ready = 1'b1;
    endtask

    initial begin
        int guard;
        repeat (3) tick();
        chk("reset_outputs", {sdbpflag, wt_valid, cfg_done, overrun, wt_addr, wt_data}, 0);

        // flat level, frame timing and period
        mode = 3'd0;
        release_reset();
        run_frame(100, rel + CFG_WAIT, -1, 0);
        write_all(0);
        mode = 3'd3;
        run_frame(100, last_start + PERIOD, -1, 0);   // uncommitted: all zero
        commit();
        run_frame(100, last_start + PERIOD, -1, 0);   // z mod 256 scaled by 255

        // split mode
        write_all(1);
        commit();
        mode = 3'd1;
        run_frame(100, last_start + PERIOD, -1, 0);

        // brightness scale, mid-stream change ignored until next frame
        write_all(2);
        commit();
        mode = 3'd2;
        bright = 8'd128;
        run_frame(100, last_start + PERIOD, 8'h33, 0);
        write_all(3);
        commit();
        run_frame(50, last_start + PERIOD, -1, 0);

        // overrun: skipped start, no swap, pending kept for the following frame
        mode = 3'd3;
        run_frame(100, last_start + PERIOD, -1, 1);
        run_frame(100, last_start + 2 * PERIOD, -1, 0);

        // commit coincident with frame start
        write_all(3);
        while (cyc < last_start + PERIOD) tick();
        commit();
        run_frame(75, last_start + PERIOD, -1, 0);

        // reset in the middle of a stream
        guard = 0;
        while (sdbpflag !== 1'b1 && guard < 3 * PERIOD) begin tick(); guard++; end
        repeat (FLAG_LEN + 10) tick();
        chk("pre_reset_valid", wt_valid, 1);
        #3 rst = 1'b1;
        #1;
        chk("reset_midsend", {sdbpflag, wt_valid, cfg_done, overrun, wt_addr, wt_data}, 0);
        tick();
        tick();

        // chase pattern from a fresh reset
        mode = 3'd4;
        release_reset();
        run_frame(100, rel + CFG_WAIT, -1, 0);
        for (int f = 1; f < 2 * CHASE_HOLD + 1; f++)
            run_frame((f % 2 == 0) ? 100 : 75, last_start + PERIOD, -1, 0);
        mode = 3'd6;
        run_frame(100, last_start + PERIOD, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
